div32_seq: RTL and testbench

- Iterative radix-2 restoring divider implementing RV32M DIV, DIVU, REM and REMU.
- Multi-cycle companion to the single-cycle combinational adder32 in the execute stage. Inverts the add/multiply direction of the ALU datapath.
- The core issues start with operands, stalls on busy, and captures result on the one-cycle done pulse.

---
 rtl/div32_seq.sv | 194 +++++++++++++++++++
 tb/tb_div32_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional macro DIV_EARLY_OUT_EN: skip the iteration loop when |dividend| < |divisor|.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    count_q, count_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    // Operand decode, only meaningful while IDLE and start is high
    logic             op_signed;
    logic             op_rem;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             div_zero;
    logic             overflow;
    logic             early;
    logic             special;

    always_comb begin
        op_signed = ~op[0];
        op_rem    = op[1];
        dvd_neg   = op_signed & dividend[WIDTH-1];
        dvs_neg   = op_signed & divisor[WIDTH-1];
        dvd_mag   = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag   = dvs_neg ? (~divisor + 1'b1) : divisor;
        div_zero  = (divisor == '0);
        overflow  = op_signed && (dividend == MOST_NEG) && (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = (dvd_mag < dvs_mag) && !div_zero && !overflow;
`else
        early     = 1'b0;
`endif
        special   = div_zero | overflow | early;
    end

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor magnitude
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = special ? FIX : CALC;
                end
            end
            CALC: begin
                if (count_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = done_q;
        result = result_q;
    end

    // Special cases preload {quo,rem} magnitudes so FIX applies one uniform sign fix-up
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        count_d   = count_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_rem_d  = op_rem;
                    neg_quo_d = (dvd_neg ^ dvs_neg) & ~div_zero;
                    neg_rem_d = dvd_neg;
                    dvs_d     = dvs_mag;
                    count_d   = '0;
                    rem_d     = '0;
                    quo_d     = dvd_mag;
                    if (div_zero) begin
                        quo_d = '1;
                        rem_d = dvd_mag;
                    end else if (overflow) begin
                        quo_d = dvd_mag;
                        rem_d = '0;
                    end else if (early) begin
                        quo_d = '0;
                        rem_d = dvd_mag;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
            end
            FIX: begin
                done_d = 1'b1;
                if (is_rem_q) begin
                    result_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                end else begin
                    result_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            count_q   <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            count_q   <= count_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - randomized self-checking bench for div32_seq against an arithmetic model
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div32_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V semantics: truncating division, remainder follows dividend sign
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int  sa;
        int  sb;
        bit  ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = !o[0];
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        begin
            longint ma;
            longint mb;
            ma = sgn ? longint'($signed(a)) : longint'(a);
            mb = sgn ? longint'($signed(b)) : longint'(b);
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
            if (ma < mb) return 1;
        end
`endif
        return 33;
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    // glitch_at > 0 pulses start with foreign operands after that many iterations.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int glitch_at, input string tag);
        int          n;
        bit          seen;
        bit          busy_ok;
        logic [31:0] exp_r;
        int          exp_l;
        exp_r    = ref_result(o, a, b);
        exp_l    = ref_latency(o, a, b);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        n        = 0;
        seen     = 0;
        busy_ok  = 1;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            if (glitch_at > 0 && n == glitch_at + 1) begin
                start    = 1'b1;
                op       = 2'b10;
                dividend = ~a;
                divisor  = 32'd7;
            end
            if (done) seen = 1;
            else if (!busy) busy_ok = 0;
        end
        start = 1'b0;
        check({tag, " latency"}, seen ? 32'(n - 1) : 32'd999, 32'(exp_l));
        check({tag, " result"}, result, exp_r);
        check({tag, " busy"}, {30'd0, busy_ok, busy}, 32'd2);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b01, 32'd100, 32'd7, 0, "divu 100/7");
        @(negedge clk);
        check("done single pulse", {31'd0, done}, 32'd0);
        run_op(2'b11, 32'd100, 32'd7, 0, "remu 100/7");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0, "div -7/2");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "rem -7/2");
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 0, "div 7/-2");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, "rem 7/-2");
        run_op(2'b00, 32'd5, 32'd0, 0, "div 5/0");
        run_op(2'b01, 32'd5, 32'd0, 0, "divu 5/0");
        run_op(2'b11, 32'd5, 32'd0, 0, "remu 5/0");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0, "rem -5/0");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem ovf");
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divu ovf operands");
        run_op(2'b01, 32'd3, 32'd10, 0, "divu 3/10");
        run_op(2'b10, 32'hFFFF_FFFD, 32'd10, 0, "rem -3/10");
        @(negedge clk);
        run_op(2'b01, 32'd1000, 32'd3, 10, "divu 1000/3 glitch");

        // Abort mid-operation with an asynchronous reset
        @(negedge clk);
        op       = 2'b01;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        begin
            bit any_done;
            any_done = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) any_done = 1;
            end
            rst_n = 1'b1;
            repeat (25) begin
                @(negedge clk);
                if (done) any_done = 1;
            end
            check("abort no done", {31'd0, any_done}, 32'd0);
        end
        run_op(2'b01, 32'd9, 32'd3, 0, "divu 9/3 after reset");

        // Randomized, mostly back-to-back traffic
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            run_op(ro, ra, rb, 0, $sformatf("rand%0d op%0d %h/%h", i, ro, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
